// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared constants for the full-speed USB transmitter
package usb_tx_pkg;
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SYNC    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] EOP_SE0 = 3'd3;
  localparam logic [2:0] EOP_J   = 3'd4;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
endpackage

// File: rtl/usb_tx_stuff_nrzi.sv
// usb_tx_stuff_nrzi: bit stuffer and NRZI encoder advanced once per emitted bit time
module usb_tx_stuff_nrzi
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic emit,
  input  logic bit_in,
  input  logic bit_valid,
  output logic level,
  output logic stuff_pending
);
  logic [2:0] ones_cnt;
  logic [2:0] base_ones;
  logic       base_level;
  logic       pend;
  logic       toggle;
  // clear starts a packet from idle J with an empty run, in the same cycle as the first emit
  assign base_level = clear | level;
  assign base_ones  = clear ? 3'd0 : ones_cnt;
  assign pend       = !clear && stuff_pending;
  assign toggle     = pend || !bit_in;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level         <= 1'b1;
      ones_cnt      <= 3'd0;
      stuff_pending <= 1'b0;
    end else if (emit && (pend || bit_valid)) begin
      level         <= toggle ? !base_level : base_level;
      ones_cnt      <= toggle ? 3'd0 : base_ones + 3'd1;
      stuff_pending <= !toggle && (base_ones + 3'd1 == STUFF_LIMIT);
    end
  end
endmodule

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB packet transmitter (SYNC, stuffed NRZI data, EOP)
module usb_fs_tx
  import usb_tx_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun,
  output logic       usb_p_tx,
  output logic       usb_n_tx,
  output logic       usb_tx_en
);
  localparam int DW = $clog2(CLK_DIV);
  logic [2:0]    state;
  logic [2:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [7:0]    shreg;
  logic          last;
  logic          in_stuff;
  logic          fin;
  logic          active;
  logic          strobe;
  logic          start;
  logic          byte_end;
  logic          accept_next;
  logic          data_done;
  logic          emit;
  logic          bit_in;
  logic          bit_valid;
  logic          level;
  logic          stuff_pending;
  assign active      = state == SYNC || state == DATA;
  assign strobe      = state != IDLE && div_cnt == DW'(CLK_DIV - 1);
  assign start       = state == IDLE && tx_valid;
  assign byte_end    = state == DATA && strobe && !in_stuff && bit_cnt == 3'd7;
  assign tx_ready    = state == IDLE || (byte_end && !last);
  assign accept_next = byte_end && !last && tx_valid;
  assign tx_underrun = byte_end && !last && !tx_valid;
  assign data_done   = bit_cnt == 3'd7 && !accept_next;
  assign emit        = start || (strobe && active);
  // next raw bit to put on the line; ignored by the encoder while a stuff bit is owed
  assign bit_in = start ? SYNC_PATTERN[0] :
                  state == SYNC ? (bit_cnt == 3'd7 ? shreg[0] : SYNC_PATTERN[bit_cnt + 3'd1]) :
                  in_stuff ? shreg[bit_cnt] :
                  bit_cnt == 3'd7 ? tx_data[0] : shreg[bit_cnt + 3'd1];
  assign bit_valid = start || state == SYNC || (in_stuff ? !fin : (bit_cnt != 3'd7 || accept_next));
  assign tx_busy   = state != IDLE;
  assign usb_tx_en = tx_busy;
  assign {usb_p_tx, usb_n_tx} = active ? (level ? LINE_J : LINE_K) :
                                state == EOP_SE0 ? LINE_SE0 : LINE_J;
  usb_tx_stuff_nrzi u_stuff (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (start),
    .emit         (emit),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .level        (level),
    .stuff_pending(stuff_pending)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= 3'd0;
      shreg    <= 8'd0;
      last     <= 1'b0;
      in_stuff <= 1'b0;
      fin      <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= state == EOP_J && strobe;
      div_cnt <= (start || strobe) ? '0 : tx_busy ? div_cnt + DW'(1) : div_cnt;
      if (start) begin
        state    <= SYNC;
        bit_cnt  <= 3'd0;
        shreg    <= tx_data;
        last     <= tx_last;
        in_stuff <= 1'b0;
        fin      <= 1'b0;
      end else if (strobe) begin
        if (state == SYNC) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= DATA;
        end else if (state == DATA) begin
          if (in_stuff) begin
            in_stuff <= 1'b0;
            if (fin) begin
              state   <= EOP_SE0;
              bit_cnt <= 3'd0;
            end
          end else begin
            // fin remembers that the data ended, so the owed stuff bit goes out before EOP
            in_stuff <= stuff_pending;
            fin      <= data_done;
            bit_cnt  <= data_done ? 3'd0 : bit_cnt + 3'd1;
            if (accept_next) begin
              shreg <= tx_data;
              last  <= tx_last;
            end
            if (data_done && !stuff_pending) state <= EOP_SE0;
          end
        end else if (state == EOP_SE0) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(EOP_SE0_BITS - 1)) state <= EOP_J;
        end else begin
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: randomized packets checked against a bit-list model of the USB line
module tb_usb_fs_tx;
  localparam int DIV  = 4;
  localparam int EOPB = 2;
  localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic tx_ready, tx_busy, tx_done, tx_underrun, usb_p_tx, usb_n_tx, usb_tx_en;
  logic [7:0] pkt [4];
  logic [7:0] nxt;
  logic nxt_last;
  int n_chk = 0;
  int n_fail = 0;
  usb_fs_tx #(.CLK_DIV(DIV), .EOP_SE0_BITS(EOPB)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_underrun(tx_underrun),
    .usb_p_tx(usb_p_tx), .usb_n_tx(usb_n_tx), .usb_tx_en(usb_tx_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // n bytes from pkt[]; und: last byte not flagged and nothing follows; chain: pkt[0] was
  // accepted at the end of the previous packet; hold: keep offering nxt through the EOP
  task automatic run_pkt(input int n, input bit und, input bit chain, input bit hold);
    bit bits[$];
    logic [1:0] sym[$];
    logic [2:0] trace[$];
    int pos7[4];
    int acc[4];
    int ones, idx, cyc, en_start, und_off, und_cnt, done_off, done_cnt, extra, len;
    logic lv;
    logic [11:0] got;
    bit fin;
    ones = 1;
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) begin
        bits.push_back(pkt[k][i]);
        ones = pkt[k][i] ? ones + 1 : 0;
        if (i == 7) pos7[k] = bits.size() - 1;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    lv = 1'b1;
    foreach (bits[i]) begin
      if (!bits[i]) lv = !lv;
      sym.push_back(lv ? J : K);
    end
    for (int i = 0; i < EOPB; i++) sym.push_back(SE0);
    sym.push_back(J);
    len = sym.size();
    idx = chain ? 1 : 0;
    en_start = -1; und_off = -1; und_cnt = 0; done_off = -1; done_cnt = 0; extra = -1; fin = 0;
    for (int k = 0; k < 4; k++) acc[k] = -1;
    for (cyc = 0; cyc < DIV * len + 40 && !fin; cyc++) begin
      @(negedge clk);
      if (idx < n) begin
        tx_valid = 1'b1; tx_data = pkt[idx]; tx_last = (idx == n - 1) && !und;
      end else if (hold) begin
        tx_valid = 1'b1; tx_data = nxt; tx_last = nxt_last;
      end else begin
        tx_valid = 1'b0; tx_data = 8'($urandom); tx_last = 1'($urandom);
      end
      #1;
      if (usb_tx_en && en_start < 0) en_start = cyc;
      if (usb_tx_en) trace.push_back({tx_busy, usb_p_tx, usb_n_tx});
      if (tx_underrun) begin und_cnt++; und_off = cyc - en_start; end
      if (tx_done) begin done_cnt++; done_off = cyc - en_start; end
      if (tx_ready && tx_valid) begin
        if (idx < n) begin acc[idx] = cyc; idx++; end
        else if (extra < 0) extra = cyc - en_start;
      end
      if (en_start >= 0 && cyc - en_start == DIV * len) fin = 1;
    end
    chk("finish_in_time", 32'(fin), 32'd1);
    chk("en_latency", en_start, chain ? 0 : acc[0] + 1);
    chk("en_cycles", trace.size(), DIV * len);
    for (int s = 0; s < len; s++)
      if (DIV * s + DIV - 1 < trace.size()) begin
        got = '0;
        for (int j = 0; j < DIV; j++) got = {got[8:0], trace[DIV * s + j]};
        chk($sformatf("line_bit%0d", s), 32'(got), 32'({4{1'b1, sym[s]}}));
      end
    for (int k = 1; k < n; k++) chk($sformatf("accept_byte%0d", k), acc[k] - en_start, DIV * pos7[k-1] + DIV - 1);
    chk("underrun_count", und_cnt, 32'(und));
    if (und) chk("underrun_at", und_off, DIV * pos7[n-1] + DIV - 1);
    chk("done_count", done_cnt, 1);
    chk("done_at", done_off, DIV * len);
    if (hold) chk("hold_accept_at", extra, DIV * len);
  endtask
  initial begin
    bit chain;
    repeat (3) @(negedge clk);
    chk("rst_p", 32'(usb_p_tx), 1);
    chk("rst_n", 32'(usb_n_tx), 0);
    chk("rst_en", 32'(usb_tx_en), 0);
    chk("rst_ready", 32'(tx_ready), 1);
    chk("rst_busy", 32'(tx_busy), 0);
    chk("rst_done", 32'(tx_done), 0);
    reset_n = 1'b1;
    @(negedge clk);
    pkt[0] = 8'h00; run_pkt(1, 0, 0, 0);
    pkt[0] = 8'hFF; run_pkt(1, 0, 0, 0);
    pkt[0] = 8'hFF; pkt[1] = 8'hFF; run_pkt(2, 0, 0, 0);
    pkt[0] = 8'hA5; run_pkt(1, 1, 0, 0);
    pkt[0] = 8'hFC; run_pkt(1, 0, 0, 0);
    pkt[0] = 8'h5A; nxt = 8'h0F; nxt_last = 1'b1; run_pkt(1, 0, 0, 1);
    pkt[0] = nxt; run_pkt(1, 0, 1, 0);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h3C; tx_last = 1'b0;
    @(negedge clk); tx_valid = 1'b0;
    repeat (44) @(negedge clk);
    #1 chk("busy_before_reset", 32'(tx_busy), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_en", 32'(usb_tx_en), 0);
    chk("midrst_p", 32'(usb_p_tx), 1);
    chk("midrst_n", 32'(usb_n_tx), 0);
    chk("midrst_busy", 32'(tx_busy), 0);
    chk("midrst_ready", 32'(tx_ready), 1);
    @(negedge clk); reset_n = 1'b1;
    pkt[0] = 8'hC3; pkt[1] = 8'h7E; run_pkt(2, 0, 0, 0);
    chain = 0;
    for (int r = 0; r < 24 || chain; r++) begin
      int n;
      bit und, hold;
      for (int k = 0; k < 4; k++) pkt[k] = $urandom_range(0, 2) == 0 ? 8'hFF : 8'($urandom);
      if (chain) pkt[0] = nxt;
      n = chain ? (nxt_last ? 1 : int'($urandom_range(2, 4))) : int'($urandom_range(1, 4));
      und = (n > 1 || !chain) && $urandom_range(0, 4) == 0;
      hold = !und && r < 24 && $urandom_range(0, 2) == 0;
      if (hold) begin nxt = 8'($urandom); nxt_last = 1'($urandom); end
      if (!chain) repeat ($urandom_range(0, 3)) begin @(negedge clk); tx_valid = 1'b0; end
      run_pkt(n, und, chain, hold);
      chain = hold;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d checks failed so far", n_fail, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/usb_fs_tx.md
Name: usb_fs_tx

Overview:
- Full-speed USB packet transmitter. Serialises a byte stream into line states on usb_p_tx/usb_n_tx/usb_tx_en, which drive the iCE40 USB PHY tristate pads.
- Generates SYNC, LSB-first data with bit stuffing and NRZI encoding, and EOP.
- Sits between the protocol/packet layer and the PHY. It is the transmit counterpart to the PHY's receive path.

Parameters:
- CLK_DIV, 4: clk cycles per USB bit time (48 MHz clk gives 12 Mb/s); legal values are ≥2.
- EOP_SE0_BITS, 2: number of SE0 bit times in the EOP.

Ports:
- clk  input  1  system clock (48 MHz)
- reset_n  input  1  asynchronous, active-low reset
- tx_data  input  8  byte to transmit, sent LSB first
- tx_valid  input  1  tx_data is valid
- tx_last  input  1  qualifies tx_data as the final byte of the packet
- tx_ready  output  1  byte accepted on a cycle where tx_valid && tx_ready
- tx_busy  output  1  a packet is in progress (state != IDLE)
- tx_done  output  1  one-cycle pulse after the EOP J bit completes
- tx_underrun  output  1  one-cycle pulse when a byte was needed but tx_valid was low
- usb_p_tx  output  1  D+ drive value
- usb_n_tx  output  1  D- drive value
- usb_tx_en  output  1  output enable to PHY pads

Behaviour:
- Clock/reset: single clock domain. reset_n is asynchronous assert, synchronous deassert is the caller's responsibility.
- Reset values: usb_p_tx=1, usb_n_tx=0 (J), usb_tx_en=0, tx_busy=0, tx_done=0, tx_underrun=0, state=IDLE, ones_cnt=0, div_cnt=0.
- Line encodings: J is p=1,n=0; K is p=0,n=1; SE0 is p=0,n=0.
- NRZI: a 0 bit toggles J/K; a 1 bit holds the current level. The level before SYNC is J.
- Bit timer: div_cnt counts 0..CLK_DIV-1 and is cleared on packet start. The bit strobe fires at div_cnt==CLK_DIV-1. Outputs update only on the edge after a strobe, except on the start edge.
- State IDLE:
  - tx_ready=1.
  - On accept, load the shift register with tx_data and latch tx_last.
  - On the next edge: usb_tx_en=1, go to SYNC, drive the first SYNC bit. Latency from accept to tx_en is 1 cycle.
- State SYNC: shift 8'h80 LSB first, giving line pattern KJKJKJKK. The SYNC bits feed the stuffing counter, so ones_cnt=1 on entry to DATA.
- State DATA:
  - Shift out 8 bits per byte.
  - Stuffing: after a 1 that brings ones_cnt to 6, insert a 0 bit (NRZI toggle). The stuffed 0 clears ones_cnt. Any 0 clears ones_cnt.
  - Stuff insertion applies across byte boundaries and after the final data bit, before EOP.
  - tx_ready=1 only in the cycle of the strobe that consumes bit 7 of a non-last byte (not a stuff bit). On accept, load the next byte seamlessly with no gap bit.
  - If tx_ready=1 and tx_valid=0: pulse tx_underrun and go to EOP_SE0 (after any pending stuff bit).
  - After the last byte's bit 7 (and any stuff bit): go to EOP_SE0.
- State EOP_SE0: drive SE0 for EOP_SE0_BITS bit times, then go to EOP_J.
- State EOP_J: drive J for 1 bit time. At its strobe: usb_tx_en=0, pulse tx_done, go to IDLE. IDLE output is J.
- tx_ready=0 in SYNC, EOP_SE0 and EOP_J. tx_valid is ignored outside ready cycles.
- Reset mid-packet: outputs return immediately to their reset values (tx_en=0, J). No EOP is sent, no tx_done is pulsed, and partial data is discarded.
- Stuff limit is fixed at 6 (USB 2.0 full-speed).

Decomposition:
- Package usb_tx_pkg holds:
  - state enum {IDLE, SYNC, DATA, EOP_SE0, EOP_J}
  - SYNC_PATTERN=8'h80
  - STUFF_LIMIT=6
  - line-state constants LINE_J, LINE_K, LINE_SE0 as 2-bit {p,n}
- One sub-module, usb_tx_stuff_nrzi. Per strobe it takes a raw bit plus a bit-valid input. It outputs the NRZI level and a stuff_pending flag that stalls the shifter, and holds ones_cnt and the current level.

Test Plan:
- Reset: hold reset_n=0 -> p=1, n=0, tx_en=0, tx_ready=1, tx_busy=0. Assert reset_n=0 mid-DATA -> same values asynchronously; a new packet then starts cleanly.
- Single byte 0x00 with tx_last=1:
  - Line is KJKJKJKK, then JKJKJKJK, then SE0 SE0 J.
  - tx_en high exactly 76 cycles (19 bits×4). tx_done pulses once, 76 cycles after the tx_en rise.
- Single byte 0xFF with tx_last=1:
  - After SYNC, the line holds K for 5 bits, stuffed J, holds J for 3 bits, then SE0 SE0 J.
  - tx_en high 80 cycles (20 bits).
- Two bytes 0xFF, 0xFF:
  - Stuff bits are inserted after data bit 5 and after bit 11.
  - Second tx_ready asserts on the strobe of byte-0 bit 7. There is no gap bit.
  - tx_en high (8+18+3)×4=116 cycles.
- Underrun: send byte 0xA5 with tx_last=0, then hold tx_valid=0 -> tx_underrun pulses at the bit-7 strobe, followed by SE0 SE0 J, then tx_done. No extra data bits.
- Back-to-back packets: tx_valid is held high with a new first byte during EOP_J -> it is not accepted until IDLE (tx_ready=0 during EOP), then tx_en rises 1 cycle after IDLE accept.
